// File: rtl/shift_add_multiplier.sv
// 4x4 unsigned shift-and-add multiplier.
// Each CALC cycle does one conditional add of M into A, then shifts {C,A,Q} right by one.
// After four steps the 8-bit product sits in {A,Q}.
module shift_add_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q;
  logic [3:0]  m_q;        // multiplicand
  logic [3:0]  acc_q;      // partial sum (A)
  logic        c_q;        // carry out of the add
  logic [3:0]  q_q;        // multiplier, shifting out as low product bits fill in
  logic [1:0]  cnt_q;
  logic [7:0]  product_q;
  logic        busy_q;
  logic        done_q;

  logic [4:0]  sum;
  logic [3:0]  acc_sh;
  logic [3:0]  q_sh;

  // One add-then-shift step; the carry lands in the top of A so it is never lost.
  always_comb begin
    sum = {c_q, acc_q};
    if (q_q[0]) begin
      sum = {c_q, acc_q} + {1'b0, m_q};
    end
    acc_sh = sum[4:1];
    q_sh   = {sum[0], q_q[3:1]};
  end

  // Control FSM and datapath registers with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      m_q       <= 4'd0;
      acc_q     <= 4'd0;
      c_q       <= 1'b0;
      q_q       <= 4'd0;
      cnt_q     <= 2'd0;
      product_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_q     <= a;
            q_q     <= b;
            acc_q   <= 4'd0;
            c_q     <= 1'b0;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_sh;
          q_q   <= q_sh;
          c_q   <= 1'b0;
          if (cnt_q == 2'd3) begin
            product_q <= {acc_sh, q_sh};
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: the driver pushes a*b per accepted op,
// the monitor pops on every done pulse and checks product stability in between.
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] product;
  logic       busy;
  logic       done;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         exp_q[$];
  int         exp_val;
  logic [7:0] hold_exp = 8'd0;
  bit         mon_en = 1'b0;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected product on done, otherwise product must hold its last value.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_done_exclusive", {31'd0, busy & done}, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_val = exp_q.pop_front();
          check("product", {24'd0, product}, exp_val);
          hold_exp = exp_val[7:0];
        end
      end else begin
        check("product_hold", {24'd0, product}, {24'd0, hold_exp});
      end
    end
  end

  // Call just after a rising edge with the DUT in IDLE. poke: CALC cycle index (0..3) in which
  // a spurious start with a=b=15 is driven. abort_at: CALC cycle index in which rst is raised.
  // chain: raise start during DONE and leave it high into the following IDLE cycle.
  task automatic run_op(input logic [3:0] oa, input logic [3:0] ob, input int poke,
                        input int abort_at, input bit chain);
    start = 1'b1;
    a     = oa;
    b     = ob;
    exp_q.push_back(int'(oa) * int'(ob));
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_done", {31'd0, done}, 0);
    @(posedge clk); #1;
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (i == poke) begin
        start = 1'b1;
        a     = 4'hF;
        b     = 4'hF;
      end
      if (i == abort_at) rst = 1'b1;
      @(negedge clk);
      check("calc_busy", {31'd0, busy}, 1);
      check("calc_done", {31'd0, done}, 0);
      @(posedge clk); #1;
      start = 1'b0;
      if (i == abort_at) begin
        rst = 1'b0;
        void'(exp_q.pop_back());
        hold_exp = 8'd0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_product", {24'd0, product}, 0);
        @(posedge clk); #1;
        return;
      end
    end
    if (chain) begin
      start = 1'b1;
      a     = 4'($urandom);
      b     = 4'($urandom);
    end
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 1);
    check("done_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_product", {24'd0, product}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    run_op(4'd15, 4'd15, -1, -1, 1'b0);
    run_op(4'd9, 4'd6, -1, -1, 1'b0);
    run_op(4'd0, 4'd13, -1, -1, 1'b0);
    run_op(4'd3, 4'd5, 1, -1, 1'b0);
    run_op(4'd7, 4'd7, -1, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset and start on the same edge: reset wins, nothing starts.
    run_op(4'd9, 4'd6, -1, -1, 1'b0);
    rst   = 1'b1;
    start = 1'b1;
    a     = 4'd5;
    b     = 4'd5;
    @(posedge clk); #1;
    rst      = 1'b0;
    start    = 1'b0;
    hold_exp = 8'd0;
    @(negedge clk);
    check("rst_start_busy", {31'd0, busy}, 0);
    check("rst_start_product", {24'd0, product}, 0);
    repeat (6) @(posedge clk);
    #1;

    // Back-to-back with start held from DONE into the next IDLE cycle.
    run_op(4'd1, 4'd15, -1, -1, 1'b1);
    run_op(4'd2, 4'd8, -1, -1, 1'b0);

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_op(4'(ia), 4'(ib), -1, -1, 1'b0);
      end
    end

    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 5)), -1,
             1'($urandom_range(0, 1)));
    end
    run_op(4'($urandom), 4'($urandom), -1, -1, 1'b0);

    repeat (8) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameters: none; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 a  input  4  multiplicand, unsigned; sampled on the edge that accepts start.
REQ-006 b  input  4  multiplier, unsigned; sampled on the edge that accepts start.
REQ-007 product  output  8  registered unsigned result a*b; holds its value until the next completion.
REQ-008 busy  output  1  high while a multiplication is in progress (CALC state).
REQ-009 done  output  1  single-cycle pulse marking product valid and newly updated.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-011 Internal registers SHALL be: M[3:0] (multiplicand), A[3:0] (partial sum), C (carry), Q[3:0] (multiplier/low product), cnt[1:0].
REQ-012 IDLE with start=1 at edge k: M<=a, Q<=b, A<=0, C<=0, cnt<=0, state<=CALC.
REQ-013 IDLE with start=0: all registers hold.
REQ-014 Each CALC edge: if Q[0]=1 then {C,A} = A + M (4-bit add, carry-in 0, carry-out to C), else {C,A} = {0,A}.
REQ-015 The same CALC edge then right-shifts {C,A,Q} by one bit: A<={C,A[3:1]}, Q<={A[0],Q[3:1]}, C<=0 (add and shift in one cycle, using the post-add values).
REQ-016 CALC with cnt<3: cnt<=cnt+1, stay in CALC.
REQ-017 CALC with cnt=3 (edge k+4): product<={A,Q} after the step of REQ-014/015, state<=DONE.
REQ-018 DONE: done=1 for exactly one cycle; next edge state<=IDLE unconditionally.
REQ-019 Latency: start accepted at edge k -> busy=1 for the 4 cycles following edge k -> done=1 in the cycle following edge k+4 -> IDLE after edge k+5.
REQ-020 busy SHALL be 1 only in CALC; done SHALL be 1 only in DONE; the two SHALL never be high together.
REQ-021 start in CALC or DONE SHALL be ignored, with no effect on the operation in progress or on product; no queuing.
REQ-022 Earliest back-to-back start: the cycle after done (state IDLE); throughput one result per 6 cycles.
REQ-023 product SHALL change only at the REQ-017 edge or on reset; a, b changes after acceptance SHALL not affect the result.
REQ-024 Arithmetic: unsigned; the maximum 15*15=225 SHALL fit 8 bits with no overflow; the intermediate carry C SHALL never be lost across the shift.
REQ-025 Operand 0 (either a or b) SHALL still take the full 4 CALC cycles and yield product 0x00.

Reset
REQ-026 rst=1 at a rising edge: state<=IDLE, product<=0x00, M, A, Q, C, cnt<=0; busy=0, done=0 from the next cycle.
REQ-027 rst SHALL take priority over start and over any in-progress CALC/DONE; an aborted operation SHALL produce no done pulse and no product update.
REQ-028 rst and start both high at the same edge: reset wins, start is dropped.

Verification
REQ-029 After reset, a=15, b=15, start pulse -> busy high 4 cycles, done pulse 5 cycles after start, product=0xE1 (225).
REQ-030 a=9, b=6 -> product=0x36 (54); then a=0, b=13 -> product=0x00 after the full 4-cycle CALC, done still pulses.
REQ-031 Start a=3, b=5; in cycle 2 of CALC drive start=1, a=15, b=15 -> ignored; product=0x0F; single done pulse.
REQ-032 Start a=7, b=7; assert rst in the third CALC cycle -> next cycle IDLE, busy=0, done never pulses, product=0x00.
REQ-033 Back-to-back: start a=1, b=15 (product=0x0F); start held high through done and into the following IDLE cycle -> second op (a=2, b=8) accepted only in that IDLE cycle, product=0x10 after its done.
REQ-034 Exhaustive: all 256 (a,b) pairs via start pulses -> product equals a*b at each done, with product stable between done pulses.
